// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one dmem port between the CPU and a host port.
// Optional performance counters are enabled with DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [3:0]            cpu_be,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [31:0]           cpu_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [31:0]           host_addr,
    input  logic [3:0]            host_be,
    input  logic [31:0]           host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [31:0]           host_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  misalign_err
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_conflicts,
    output logic [31:0]           perf_cpu_stalls
`endif
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        PRI_CPU  = 1'b0,
        PRI_HOST = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    owner_e        rd_owner_q, rd_owner_d;
    logic          misalign_q, misalign_d;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[31:ADDR_WIDTH+2],
                                host_addr[31:ADDR_WIDTH+2]};

    // Priority state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= PRI_CPU;
        else          state_q <= state_d;
    end

    // Hand priority to the host once it has waited long enough
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PRI_CPU:  if (starve_cnt_d == CW'(STARVE_LIMIT)) state_d = PRI_HOST;
            PRI_HOST: if (host_gnt) state_d = PRI_CPU;
        endcase
    end

    // Grants: lone requester always wins, conflicts follow priority state
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                PRI_CPU: begin
                    cpu_gnt  = cpu_req;
                    host_gnt = host_req & ~cpu_req;
                end
                PRI_HOST: begin
                    host_gnt = host_req;
                    cpu_gnt  = cpu_req & ~host_req;
                end
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Steer the granted requester onto the memory port
    always_comb begin
        mem_en    = cpu_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0;
        mem_wdata = 32'b0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr[ADDR_WIDTH+1:2];
            mem_be    = cpu_be;
            mem_wdata = cpu_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr[ADDR_WIDTH+1:2];
            mem_be    = host_be;
            mem_wdata = host_wdata;
        end
    end

    // Next values for starvation count, read owner and sticky misalign flag
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (host_gnt || !host_req)
            starve_cnt_d = '0;
        else if (starve_cnt_q != CW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;

        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !cpu_we)
            rd_owner_d = OWN_CPU;
        else if (host_gnt && !host_we)
            rd_owner_d = OWN_HOST;

        misalign_d = misalign_q
                   | (cpu_gnt  & (|cpu_addr[1:0]))
                   | (host_gnt & (|host_addr[1:0]));
    end

    // Arbitration bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
            rd_owner_q   <= OWN_NONE;
            misalign_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
            misalign_q   <= misalign_d;
        end
    end

    // Return read data only to the requester that issued the load
    always_comb begin
        cpu_rvalid  = (rd_owner_q == OWN_CPU);
        host_rvalid = (rd_owner_q == OWN_HOST);
        cpu_rdata   = cpu_rvalid  ? mem_rdata : 32'b0;
        host_rdata  = host_rvalid ? mem_rdata : 32'b0;
    end

    assign misalign_err = misalign_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflicts_q, perf_conflicts_d;
    logic [31:0] perf_cpu_stalls_q, perf_cpu_stalls_d;

    // Free-running event counters, wrap naturally
    always_comb begin
        perf_conflicts_d  = perf_conflicts_q  + {31'b0, cpu_req & host_req};
        perf_cpu_stalls_d = perf_cpu_stalls_q + {31'b0, cpu_stall};
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_conflicts_q  <= 32'b0;
            perf_cpu_stalls_q <= 32'b0;
        end else begin
            perf_conflicts_q  <= perf_conflicts_d;
            perf_cpu_stalls_q <= perf_cpu_stalls_d;
        end
    end

    assign perf_conflicts  = perf_conflicts_q;
    assign perf_cpu_stalls = perf_cpu_stalls_q;
`endif

endmodule
